// File: rtl/reg_op_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_op_pkg
//  Description : Shared opcodes and FSM state encodings for the register
//                operation sequencer and its strobe decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_op_pkg;

    localparam int OP_WIDTH = 3;

    // Single-strobe operations: the repeat count is ignored.
    localparam logic [OP_WIDTH-1:0] OP_CLR  = 3'd0;
    localparam logic [OP_WIDTH-1:0] OP_LOAD = 3'd1;
    // Repeated operations: one strobe per count.
    localparam logic [OP_WIDTH-1:0] OP_SHR  = 3'd2;
    localparam logic [OP_WIDTH-1:0] OP_ASR  = 3'd3;
    localparam logic [OP_WIDTH-1:0] OP_SHL  = 3'd4;
    localparam logic [OP_WIDTH-1:0] OP_ROR  = 3'd5;
    localparam logic [OP_WIDTH-1:0] OP_ROL  = 3'd6;
    // Signed count: positive increments, negative decrements by |count|.
    localparam logic [OP_WIDTH-1:0] OP_ADDN = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : reg_op_pkg
`default_nettype wire

// File: rtl/reg_op_sequencer_decode.sv
`default_nettype none
// ============================================================================
//  Module      : reg_op_decode
//  Description : Combinational map from the latched operation to the register
//                control strobes. Strobes and load data depend only on
//                registered sequencer state; the serial fill bits additionally
//                follow the register output in the same cycle.
//  Ports       : i_run      - sequencer is in its RUN state
//                i_op       - latched opcode
//                i_neg      - latched count sign (selects dec for ADDN)
//                i_data     - latched load value
//                i_reg_q    - current register output
//                o_cl..o_sl - control strobes, at most one high
//                o_ir/o_il  - serial fill bits for right/left shifts
//                o_in       - register load data
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_op_decode
    import reg_op_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_run,
    input  logic [OP_WIDTH-1:0]   i_op,
    input  logic                  i_neg,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_reg_q,
    output logic                  o_cl,
    output logic                  o_ld,
    output logic                  o_inc,
    output logic                  o_dec,
    output logic                  o_sr,
    output logic                  o_sl,
    output logic                  o_ir,
    output logic                  o_il,
    output logic [DATA_WIDTH-1:0] o_in
);

    // Only the end bits of the register feed back into the fill logic.
    logic w_unused_q_mid;
    assign w_unused_q_mid = ^i_reg_q[DATA_WIDTH-2:1];

    always_comb begin
        o_cl  = 1'b0;
        o_ld  = 1'b0;
        o_inc = 1'b0;
        o_dec = 1'b0;
        o_sr  = 1'b0;
        o_sl  = 1'b0;
        o_ir  = 1'b0;
        o_il  = 1'b0;
        o_in  = '0;
        if (i_run) begin
            case (i_op)
                OP_CLR:  o_cl = 1'b1;
                OP_LOAD: begin
                    o_ld = 1'b1;
                    o_in = i_data;
                end
                OP_SHR:  o_sr = 1'b1;
                OP_ASR: begin
                    o_sr = 1'b1;
                    o_ir = i_reg_q[DATA_WIDTH-1];
                end
                OP_SHL:  o_sl = 1'b1;
                OP_ROR: begin
                    o_sr = 1'b1;
                    o_ir = i_reg_q[0];
                end
                OP_ROL: begin
                    o_sl = 1'b1;
                    o_il = i_reg_q[DATA_WIDTH-1];
                end
                OP_ADDN: begin
                    o_inc = ~i_neg;
                    o_dec = i_neg;
                end
                default: ;
            endcase
        end
    end

endmodule : reg_op_decode
`default_nettype wire

// File: rtl/reg_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reg_op_sequencer
//  Description : Accepts one register operation per valid/ready handshake and
//                expands it into single-cycle control strobes for the
//                downstream general-purpose register.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                i_cmd_*/o_cmd_ready - command handshake and payload
//                i_reg_q           - register output (fill-bit feedback)
//                o_reg_*           - register control strobes / data
//                o_done            - one-cycle pulse at operation end
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_op_sequencer
    import reg_op_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [OP_WIDTH-1:0]   i_cmd_op,
    input  logic [CNT_WIDTH-1:0]  i_cmd_cnt,
    input  logic [DATA_WIDTH-1:0] i_cmd_data,
    input  logic [DATA_WIDTH-1:0] i_reg_q,
    output logic                  o_reg_cl,
    output logic                  o_reg_ld,
    output logic                  o_reg_inc,
    output logic                  o_reg_dec,
    output logic                  o_reg_sr,
    output logic                  o_reg_sl,
    output logic                  o_reg_ir,
    output logic                  o_reg_il,
    output logic [DATA_WIDTH-1:0] o_reg_in,
    output logic                  o_done
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [OP_WIDTH-1:0]     r_op;
    logic                    r_neg;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [CNT_WIDTH-1:0]    r_remaining;

    logic                    w_accept;
    logic                    w_single;
    logic                    w_cmd_neg;
    logic [CNT_WIDTH-1:0]    w_cmd_mag;
    logic [CNT_WIDTH-1:0]    w_first_cnt;

    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign w_accept    = i_cmd_valid & o_cmd_ready;

    // Pulse count for the incoming command. ADDN counts are signed; the
    // magnitude of the most negative value still fits the unsigned counter.
    assign w_single    = (i_cmd_op == OP_CLR) || (i_cmd_op == OP_LOAD);
    assign w_cmd_neg   = i_cmd_cnt[CNT_WIDTH-1];
    assign w_cmd_mag   = ((i_cmd_op == OP_ADDN) && w_cmd_neg) ? (~i_cmd_cnt + c_cnt_one)
                                                              : i_cmd_cnt;
    assign w_first_cnt = w_single ? c_cnt_one : w_cmd_mag;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // A zero count skips RUN entirely: no strobes, done next cycle.
                    w_state_nxt = (w_first_cnt == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_remaining == c_cnt_one) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_neg       <= 1'b0;
            r_data      <= '0;
            r_remaining <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op        <= i_cmd_op;
                r_neg       <= w_cmd_neg;
                r_data      <= i_cmd_data;
                r_remaining <= w_first_cnt;
            end else if (r_state == S_RUN) begin
                r_remaining <= r_remaining - c_cnt_one;
            end
        end
    end

    reg_op_decode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decode (
        .i_run   (r_state == S_RUN),
        .i_op    (r_op),
        .i_neg   (r_neg),
        .i_data  (r_data),
        .i_reg_q (i_reg_q),
        .o_cl    (o_reg_cl),
        .o_ld    (o_reg_ld),
        .o_inc   (o_reg_inc),
        .o_dec   (o_reg_dec),
        .o_sr    (o_reg_sr),
        .o_sl    (o_reg_sl),
        .o_ir    (o_reg_ir),
        .o_il    (o_reg_il),
        .o_in    (o_reg_in)
    );

endmodule : reg_op_sequencer
`default_nettype wire

// File: tb/tb_reg_op_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_reg_op_sequencer
//  Description : Drives the sequencer against a behavioural 16-bit register
//                and checks final register values, strobe counts and timing
//                against an independent operation model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_op_sequencer;
    import reg_op_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = '0;
    logic [4:0]  cmd_cnt = '0;
    logic [15:0] cmd_data = '0;
    logic        cmd_ready;
    logic        reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il, done;
    logic [15:0] reg_in;
    logic [15:0] r_q = '0;
    logic [15:0] exp_reg = '0;
    logic [5:0]  strobes;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  cnt;
        logic [15:0] val;
        int          pulses;
        int          lat;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    assign strobes = {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl};

    reg_op_sequencer #(.DATA_WIDTH(16), .CNT_WIDTH(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_cnt   (cmd_cnt),
        .i_cmd_data  (cmd_data),
        .i_reg_q     (r_q),
        .o_reg_cl    (reg_cl),
        .o_reg_ld    (reg_ld),
        .o_reg_inc   (reg_inc),
        .o_reg_dec   (reg_dec),
        .o_reg_sr    (reg_sr),
        .o_reg_sl    (reg_sl),
        .o_reg_ir    (reg_ir),
        .o_reg_il    (reg_il),
        .o_reg_in    (reg_in),
        .o_done      (done)
    );

    // Behavioural general-purpose register controlled by the sequencer.
    always_ff @(posedge clk) begin
        if (reg_cl)       r_q <= '0;
        else if (reg_ld)  r_q <= reg_in;
        else if (reg_inc) r_q <= r_q + 16'd1;
        else if (reg_dec) r_q <= r_q - 16'd1;
        else if (reg_sr)  r_q <= {reg_ir, r_q[15:1]};
        else if (reg_sl)  r_q <= {r_q[14:0], reg_il};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [2:0] op, input logic [4:0] cnt,
                                          input logic [15:0] d, input logic [15:0] q);
        logic [15:0] v;
        v = q;
        case (op)
            OP_CLR:  v = '0;
            OP_LOAD: v = d;
            OP_ADDN: v = q + {{11{cnt[4]}}, cnt};
            default: begin
                for (int i = 0; i < int'(cnt); i++) begin
                    case (op)
                        OP_SHR:  v = v >> 1;
                        OP_ASR:  v = {v[15], v[15:1]};
                        OP_SHL:  v = v << 1;
                        OP_ROR:  v = {v[0], v[15:1]};
                        default: v = {v[14:0], v[15]};
                    endcase
                end
            end
        endcase
        return v;
    endfunction

    function automatic int pulses_of(input logic [2:0] op, input logic [4:0] cnt);
        if (op == OP_CLR || op == OP_LOAD) return 1;
        if (op == OP_ADDN && cnt[4])       return 32 - int'(cnt);
        return int'(cnt);
    endfunction

    // The strobe this operation is supposed to use.
    function automatic logic kind_hit(input logic [2:0] op, input logic [4:0] cnt);
        case (op)
            OP_CLR:                 return reg_cl;
            OP_LOAD:                return reg_ld;
            OP_SHR, OP_ASR, OP_ROR: return reg_sr;
            OP_SHL, OP_ROL:         return reg_sl;
            default:                return cnt[4] ? reg_dec : reg_inc;
        endcase
    endfunction

    task automatic push_expected(input logic [2:0] op, input logic [4:0] cnt, input logic [15:0] d);
        sb_t e;
        e.op     = op;
        e.cnt    = cnt;
        e.val    = model(op, cnt, d, exp_reg);
        e.pulses = pulses_of(op, cnt);
        e.lat    = 1 + e.pulses;
        exp_reg  = e.val;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [4:0] cnt, input logic [15:0] d, input bit hold);
        int w;
        w = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_data  = d;
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("issue_ready", cmd_ready, 1'b1);
        @(posedge clk);
        push_expected(op, cnt, d);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Monitors one operation to completion and scores it; ends at a negedge
    // in the first cycle after done, where the next command may be offered.
    task automatic complete(input string tag);
        sb_t e;
        int  pulses, kind, k;
        bit  got;
        pulses = 0; kind = 0; k = 0; got = 0;
        chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1'b1);
        if (sb.size() == 0) return;
        e = sb[0];
        while (!got && k < 80) begin
            @(negedge clk);
            k++;
            chk({tag, "_onehot"}, ($countones(strobes) <= 1), 1'b1);
            chk({tag, "_ready_busy"}, cmd_ready, 1'b0);
            if (done) begin
                got = 1;
                chk({tag, "_no_strobe_in_done"}, strobes, 6'd0);
            end else begin
                if (strobes != 6'd0)       pulses++;
                if (kind_hit(e.op, e.cnt)) kind++;
            end
        end
        chk({tag, "_done_seen"}, got, 1'b1);
        void'(sb.pop_front());
        chk({tag, "_reg"}, r_q, e.val);
        chk({tag, "_pulses"}, pulses, e.pulses);
        chk({tag, "_kind"}, kind, e.pulses);
        chk({tag, "_latency"}, k, e.lat);
        @(negedge clk);
        chk({tag, "_ready_again"}, cmd_ready, 1'b1);
        chk({tag, "_done_once"}, done, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_strobes", strobes, 6'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_in", reg_in, 16'h0000);
        chk("rst_fill", {reg_ir, reg_il}, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        // LOAD then ROR by 4
        issue(OP_LOAD, 5'd0, 16'h1234, 0); complete("ld1234");
        issue(OP_ROR,  5'd4, 16'h0000, 0); complete("ror4");
        chk("ror4_value", r_q, 16'h4123);

        // Arithmetic then long logical shift
        issue(OP_LOAD, 5'd0,  16'h8000, 0); complete("ld8000");
        issue(OP_ASR,  5'd2,  16'h0000, 0); complete("asr2");
        chk("asr2_value", r_q, 16'hE000);
        issue(OP_SHR,  5'd20, 16'h0000, 0); complete("shr20");
        chk("shr20_value", r_q, 16'h0000);

        // Increment wrap and signed decrement
        issue(OP_LOAD, 5'd0,      16'hFFFE, 0); complete("ldfffe");
        issue(OP_ADDN, 5'd3,      16'h0000, 0); complete("addp3");
        chk("addp3_value", r_q, 16'h0001);
        issue(OP_ADDN, 5'b11110,  16'h0000, 0); complete("addm2");
        chk("addm2_value", r_q, 16'hFFFF);

        // Zero-count SHL with valid held; the next command goes in at T+2
        issue(OP_SHL, 5'd0, 16'h0000, 1);
        @(negedge clk);
        chk("z_done", done, 1'b1);
        chk("z_ready", cmd_ready, 1'b0);
        chk("z_strobes", strobes, 6'd0);
        chk("z_reg", r_q, sb[0].val);
        void'(sb.pop_front());
        cmd_op   = OP_LOAD;
        cmd_cnt  = 5'd0;
        cmd_data = 16'hA5C3;
        @(negedge clk);
        chk("z_ready_t2", cmd_ready, 1'b1);
        chk("z_done_once", done, 1'b0);
        @(posedge clk);
        push_expected(OP_LOAD, 5'd0, 16'hA5C3);
        #1 cmd_valid = 1'b0;
        complete("b2b_load");
        chk("b2b_value", r_q, 16'hA5C3);

        // Reset during the 4th RUN cycle of ROL by 8
        issue(OP_LOAD, 5'd0, 16'h00FF, 0); complete("ld00ff");
        issue(OP_ROL,  5'd8, 16'h0000, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("abort_sl", reg_sl, 1'b1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_strobes", strobes, 6'd0);
        chk("abort_done", done, 1'b0);
        chk("abort_ready", cmd_ready, 1'b1);
        rst = 1'b0;
        void'(sb.pop_front());
        exp_reg = 16'h0FF0;
        chk("abort_value", r_q, 16'h0FF0);
        @(negedge clk);
        chk("abort_done2", done, 1'b0);
        chk("abort_strobes2", strobes, 6'd0);
        issue(OP_ROR, 5'd1, 16'h0000, 0); complete("after_abort");
        chk("after_abort_value", r_q, 16'h07F8);

        // Random command stream
        for (int n = 0; n < 1000; n++) begin
            logic [2:0] op;
            logic [4:0] cnt;
            op  = 3'($urandom_range(0, 7));
            cnt = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(negedge clk);
                    chk("rnd_idle_strobes", strobes, 6'd0);
                end
            end
            issue(op, cnt, 16'($urandom), 0);
            complete("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_op_sequencer
`default_nettype wire
